// File: rtl/rdma_stream_pkg.sv
// rdma_stream_pkg: beat type and arbiter state encoding shared by the network TX stream path
package rdma_stream_pkg;
    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_beat_t;

    typedef enum logic {IDLE, LOCK} arb_state_t;
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2: two-entry skid buffer on axis_beat_t with a registered output
module axis_skid2
    import rdma_stream_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  axis_beat_t i_beat,
    output logic       o_valid,
    input  logic       i_ready,
    output axis_beat_t o_beat
);
    logic [1:0] r_count;
    axis_beat_t r_head;
    axis_beat_t r_tail;
    logic       w_push;
    logic       w_pop;

    assign o_ready = (r_count < 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_beat  = r_head;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // head only moves on pop or when loading into an empty (or emptying) buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push && (r_count == 2'd0 || (r_count == 2'd1 && w_pop)))
                r_head <= i_beat;
            else if (w_pop && r_count == 2'd2)
                r_head <= r_tail;
            if (w_push && r_count == 2'd1 && !w_pop)
                r_tail <= i_beat;
        end
    end
endmodule

// File: rtl/rdma_tx_arbiter.sv
// rdma_tx_arbiter: packet-locked round-robin arbiter sharing the network TX stream
// between RDMA requesters, with a registered skid stage toward the CMAC.
module rdma_tx_arbiter #(
    parameter int N_SRC    = 3,
    parameter int DATA_W   = 512,
    parameter int PRIO_SRC = 0
) (
    input  logic                      nclk,
    input  logic                      nresetn,
    input  logic [N_SRC-1:0]          s_tvalid,
    output logic [N_SRC-1:0]          s_tready,
    input  logic [N_SRC*DATA_W-1:0]   s_tdata,
    input  logic [N_SRC*DATA_W/8-1:0] s_tkeep,
    input  logic [N_SRC-1:0]          s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [DATA_W/8-1:0]       m_tkeep,
    output logic                      m_tlast,
    output logic [$clog2(N_SRC)-1:0]  grant_id,
    output logic                      busy
);
    import rdma_stream_pkg::*;

    localparam int IDW      = $clog2(N_SRC);
    localparam int KW       = DATA_W / 8;
    localparam bit PRIO_EN  = (PRIO_SRC >= 0) && (PRIO_SRC < N_SRC);
    localparam int PRIO_IDX = PRIO_EN ? PRIO_SRC : 0;

    // {found, index}: descending scan so the lowest offset from ptr wins
    function automatic logic [IDW:0] rr_pick(input logic [N_SRC-1:0] v,
                                             input logic [IDW-1:0]   ptr,
                                             input logic             first);
        logic [IDW:0] r;
        int           k;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N_SRC;
            if (v[k]) r = {1'b1, IDW'(k)};
        end
        if (PRIO_EN && first && v[PRIO_IDX]) r = {1'b1, IDW'(PRIO_IDX)};
        return r;
    endfunction

    arb_state_t     r_state;
    arb_state_t     w_state_nx;
    logic [IDW-1:0] r_grant;
    logic [IDW-1:0] r_rr_ptr;
    logic           r_first;
    logic [IDW:0]   w_pick;
    logic           w_in_valid;
    logic           w_in_ready;
    logic           w_out_valid;
    axis_beat_t     w_in_beat;
    axis_beat_t     w_out_beat;

    assign w_pick    = rr_pick(s_tvalid, r_rr_ptr, r_first);
    assign w_in_beat = '{data: s_tdata[r_grant*DATA_W +: DATA_W],
                         keep: s_tkeep[r_grant*KW +: KW],
                         last: s_tlast[r_grant]};

    always_comb begin
        w_state_nx = r_state;
        s_tready   = '0;
        w_in_valid = 1'b0;
        if (r_state == IDLE) begin
            w_state_nx = w_pick[IDW] ? LOCK : IDLE;
        end else begin
            s_tready[r_grant] = w_in_ready;
            w_in_valid        = s_tvalid[r_grant];
            w_state_nx        = (w_in_valid && w_in_ready && s_tlast[r_grant]) ? IDLE : LOCK;
        end
    end

    always_ff @(posedge nclk or negedge nresetn) begin
        if (!nresetn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_first  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && w_pick[IDW]) begin
                r_grant  <= w_pick[IDW-1:0];
                r_rr_ptr <= IDW'((int'(w_pick[IDW-1:0]) + 1) % N_SRC);
                r_first  <= 1'b0;
            end
        end
    end

    axis_skid2 u_skid (
        .i_clk   (nclk),
        .i_rst_n (nresetn),
        .i_valid (w_in_valid),
        .o_ready (w_in_ready),
        .i_beat  (w_in_beat),
        .o_valid (w_out_valid),
        .i_ready (m_tready),
        .o_beat  (w_out_beat)
    );

    assign m_tvalid = w_out_valid;
    assign m_tdata  = w_out_beat.data;
    assign m_tkeep  = w_out_beat.keep;
    assign m_tlast  = w_out_beat.last;
    assign grant_id = r_grant;
    assign busy     = (r_state == LOCK);
endmodule

// File: tb/tb_rdma_tx_arbiter.sv
// tb_rdma_tx_arbiter: directed scoreboard bench for the packet-locked TX arbiter
module tb_rdma_tx_arbiter;
    localparam int N  = 3;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } bt_t;

    logic          nclk = 1'b0;
    logic          nresetn = 1'b0;
    logic [N-1:0]  s_tvalid = '0;
    logic [N-1:0]  s_tready;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*KW-1:0] s_tkeep = '0;
    logic [N-1:0]  s_tlast = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [1:0]    grant_id;
    logic          busy;

    bt_t          sq[N][$];
    bt_t          exp_q[$];
    logic [N-1:0] hold = '0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 nclk = ~nclk;

    rdma_tx_arbiter #(.N_SRC(N), .DATA_W(DW), .PRIO_SRC(0)) dut (
        .nclk     (nclk),
        .nresetn  (nresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .grant_id (grant_id),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // beat byte0 = source, byte1 = beat index; second beat of src1 packets carries zero keep
    task automatic add_pkt(input int src, input int nb);
        bt_t b;
        for (int i = 0; i < nb; i++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
            b.d[7:0]  = 8'(src);
            b.d[15:8] = 8'(i);
            b.k = (src == 1 && i == 1) ? '0 : {$urandom, $urandom};
            b.l = (i == nb - 1);
            sq[src].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = (sq[i].size() > 0) && !hold[i];
            s_tdata[i*DW +: DW] = (sq[i].size() > 0) ? sq[i][0].d : '0;
            s_tkeep[i*KW +: KW] = (sq[i].size() > 0) ? sq[i][0].k : '0;
            s_tlast[i] = (sq[i].size() > 0) ? sq[i][0].l : 1'b0;
        end
    endtask

    // sample at negedge, advance sources just after the posedge
    task automatic tick();
        logic [N-1:0] xf;
        logic [N-1:0] allow;
        bt_t          e;
        @(negedge nclk);
        xf = s_tvalid & s_tready;
        allow = busy ? (N'(1) << grant_id) : '0;
        chk("tready_only_granted", s_tready & ~allow, 0);
        if (m_tvalid && m_tready) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_tdata", m_tdata, e.d);
                chk("m_tkeep", m_tkeep, e.k);
                chk("m_tlast", m_tlast, e.l);
            end
        end
        @(posedge nclk);
        #1;
        for (int i = 0; i < N; i++) if (xf[i]) sq[i].delete(0);
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        hold = '0;
        drive();
    endtask

    task automatic do_reset();
        nresetn = 1'b0;
        clear_src();
        repeat (2) @(posedge nclk);
        @(negedge nclk);
        nresetn = 1'b1;
        @(posedge nclk);
        #1;
    endtask

    task automatic drain(input string tag);
        int b = 0;
        while ((exp_q.size() > 0 || busy) && b < 200) begin
            tick();
            b++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int b;
        drive();
        #12;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        @(negedge nclk);
        nresetn = 1'b1;
        @(posedge nclk);
        #1;

        // single 2-beat packet from src1
        add_pkt(1, 2);
        drive();
        chk("t1_idle_tready", s_tready, 0);
        tick();
        chk("t1_tready_after_req", s_tready, 3'b010);
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_id, 1);
        chk("t1_no_out_yet", m_tvalid, 0);
        tick();
        chk("t1_out_after_xfer", m_tvalid, 1);
        tick();
        chk("t1_back_idle", busy, 0);
        chk("t1_grant_held", grant_id, 1);
        tick();
        chk("t1_out_empty", m_tvalid, 0);
        chk("t1_all_out", exp_q.size(), 0);

        // round robin over three continuously valid sources
        do_reset();
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_pkt(s, 1);
        drive();
        drain("t2_drain");

        // src2 arrives mid-packet and must wait for src0's tlast
        add_pkt(0, 4);
        drive();
        tick();
        tick();
        add_pkt(2, 2);
        drive();
        b = 0;
        while (busy && b < 20) begin
            chk("t3_src2_blocked", s_tready[2], 0);
            tick();
            b++;
        end
        chk("t3_bubble_idle", busy, 0);
        chk("t3_bubble_tready", s_tready, 0);
        tick();
        chk("t3_grant_src2", grant_id, 2);
        chk("t3_busy_src2", busy, 1);
        drain("t3_drain");

        // output backpressure for five cycles mid-packet
        add_pkt(1, 6);
        drive();
        repeat (3) tick();
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_tready_low", s_tready, 0);
            chk("t4_tvalid_held", m_tvalid, 1);
            chk("t4_tdata_stable", m_tdata, exp_q[0].d);
        end
        m_tready = 1'b1;
        drain("t4_drain");

        // granted source stalls while another requests
        add_pkt(0, 3);
        drive();
        tick();
        tick();
        hold[0] = 1'b1;
        add_pkt(1, 1);
        drive();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_lock_busy", busy, 1);
            chk("t5_lock_grant", grant_id, 0);
            chk("t5_other_blocked", s_tready[1], 0);
        end
        hold[0] = 1'b0;
        drive();
        drain("t5_drain");

        // asynchronous reset mid-packet
        add_pkt(0, 6);
        drive();
        repeat (3) tick();
        #2;
        nresetn = 1'b0;
        #1;
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_s_tready", s_tready, 0);
        chk("t6_busy", busy, 0);
        clear_src();
        @(negedge nclk);
        nresetn = 1'b1;
        @(posedge nclk);
        #1;
        add_pkt(0, 1);
        add_pkt(1, 1);
        add_pkt(2, 1);
        drive();
        tick();
        chk("t6_prio_grant", grant_id, 0);
        chk("t6_prio_busy", busy, 1);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rdma_tx_arbiter.md
Name: rdma_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 512-bit network TX AXI-Stream between N_SRC RDMA requesters, such as the trimmed read-request path, the write/send path and the ACK generator.
- It locks a grant from the first beat to tlast, so packets never interleave.
- It drives the network through a registered two-entry skid stage.
- It sits between the per-requester stream producers (downstream of the read-request trimming stage) and the CMAC TX interface.

Parameters:
- N_SRC, 3, number of requesting streams (2..8).
- DATA_W, 512, tdata width in bits.
- PRIO_SRC, 0, source index that wins ties when the round-robin pointer is at reset position; -1 disables this.

Ports:
- nclk  in  1  network clock.
- nresetn  in  1  asynchronous active-low reset.
- s_tvalid  in  N_SRC  per-source valid.
- s_tready  out  N_SRC  per-source ready.
- s_tdata  in  N_SRC*DATA_W  per-source data; source i occupies [i*DATA_W +: DATA_W].
- s_tkeep  in  N_SRC*DATA_W/8  per-source byte enables.
- s_tlast  in  N_SRC  per-source end of packet.
- m_tvalid  out  1  to network.
- m_tready  in  1  from network.
- m_tdata  out  DATA_W.
- m_tkeep  out  DATA_W/8.
- m_tlast  out  1.
- grant_id  out  $clog2(N_SRC)  currently locked source; valid while busy.
- busy  out  1  a packet is in flight through the arbiter (state LOCK).

Behaviour:
- Reset values (async on nresetn low):
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0.
  - s_tready all 0, m_tvalid=0, skid buffer empty.
  - m_tdata/m_tkeep/m_tlast are 0.
- FSM states: IDLE, LOCK.
- IDLE:
  - Search s_tvalid round-robin starting at rr_ptr (indices rr_ptr, rr_ptr+1, ... modulo N_SRC).
  - The first set bit wins. On the first arbitration after reset, PRIO_SRC is checked first.
  - On any valid request: grant_id<=winner, rr_ptr<=(winner+1) mod N_SRC, go to LOCK.
  - s_tready stays 0 in IDLE. No beat is consumed in the arbitration cycle.
- LOCK:
  - s_tready[grant_id] = skid_in_ready. All other s_tready are 0.
  - A beat transfers when s_tvalid[grant_id] && s_tready[grant_id]. It is pushed into the skid stage unmodified (data, keep, last).
  - A transfer with s_tlast=1 returns to IDLE next cycle. Arbitration can then start in that IDLE cycle, which gives a one-cycle bubble per packet.
  - Deasserting s_tvalid mid-packet holds the lock. There is no timeout.
- Skid stage:
  - Two entries; output is always registered.
  - skid_in_ready = (count<2).
  - Full throughput: one beat/cycle when m_tready is held high.
  - Simultaneous push and pop at count=2 is not possible because in_ready=0 then.
  - Simultaneous push and pop at count=1 keeps count=1.
  - m_tvalid=(count>0). The head changes only on pop (m_tvalid && m_tready).
  - Contents are held stable while m_tready=0 (AXI-Stream rule: no m_tvalid drop, no data change).
- Latency:
  - Request to first s_tready: 1 cycle.
  - Input transfer to m_tvalid: 1 cycle.
  - Minimum first-beat latency: 2 cycles.
- Fairness: a source that is continuously valid waits at most N_SRC-1 packets.
- Single-source case: back-to-back packets from the same source are allowed. rr_ptr rotation skips non-valid sources.
- Mid-packet reset: all state clears immediately. A partial packet is dropped. The producer must also be reset in the same domain.
- Zero-keep beats pass through unmodified. The arbiter never inspects payload.

Decomposition:
- Shared package rdma_stream_pkg:
  - constant DATA_W=512, KEEP_W=DATA_W/8.
  - typedef struct packed {data, keep, last} axis_beat_t.
  - enum arb_state_t {IDLE, LOCK}.
- Sub-module axis_skid2: the two-entry registered skid buffer on axis_beat_t. It is reusable elsewhere on network paths.
- Round-robin search is an inline function, not a module.

Test Plan:
1. Reset, then src1 sends one 2-beat packet with m_tready=1 -> s_tready[1] rises 1 cycle after s_tvalid[1]. m_tvalid follows 1 cycle after each transfer, with 2 beats, tlast on beat 2, and data/keep bit-exact. Return to IDLE. grant_id=1.
2. All 3 sources continuously offer 1-beat packets -> output order src0,src1,src2,src0,src1,src2. No source is ever served twice in a row.
3. src0 sends a 4-beat packet; src2 raises valid at beat 2 -> src2 gets no s_tready until src0's tlast transfers. Then src2's packet follows after a 1-cycle bubble with no interleaving.
4. Backpressure: m_tready=0 for 5 cycles mid-packet -> skid fills to 2, s_tready drops, m_tdata is stable and m_tvalid stays high. On release, all beats emerge in order with no loss or duplication.
5. Granted source drops s_tvalid for 3 cycles mid-packet while another source is valid -> the lock is held, the other source is not granted, and the packet resumes intact.
6. Assert nresetn=0 asynchronously mid-packet (between clock edges) -> m_tvalid=0, s_tready=0 and busy=0 immediately. After release, the first grant goes to PRIO_SRC when it is valid together with others.
